// File: rtl/fan_tach_meter_pkg.sv
// Shared definitions for the fan tachometer meter and the fan controller:
// default widths and the gate-window FSM state encoding.
package fan_tach_meter_pkg;

    localparam int ADC_BITWIDTH_DEF  = 4;
    localparam int GATE_BITWIDTH_DEF = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        LATCH = 2'd2
    } gate_state_t;

endpackage

// File: rtl/fan_tach_meter_tach_debounce.sv
// Tachometer input conditioning: two-FF synchroniser, tick-based debounce
// filter and rising-edge detector on the debounced level.
module tach_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clk_en_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_CYCLES);

    logic       sync_p0;
    logic       sync_p1;
    logic [3:0] db_cnt;
    logic       accept;

    // The new level is taken on the tick that completes the persistence count.
    assign accept = clk_en_i && (sync_p1 != level_o) && ((db_cnt + 4'd1) == DB_LIMIT);
    // Rise coincides with the level update, so it always lands on a tick.
    assign rise_o = accept && sync_p1;

    // Synchroniser runs every clock, independent of the tick enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw_i;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: count ticks the synchronised input disagrees with the level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_o <= 1'b0;
            db_cnt  <= '0;
        end else if (clk_en_i) begin
            if (sync_p1 != level_o) begin
                if (accept) begin
                    level_o <= sync_p1;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 4'd1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/fan_tach_meter.sv
// Fan tachometer meter: counts debounced tach rises over a programmable gate
// window and converts the count into a saturated speed value plus a stall flag.
module fan_tach_meter
    import fan_tach_meter_pkg::*;
#(
    parameter int ADC_BITWIDTH    = ADC_BITWIDTH_DEF,
    parameter int GATE_BITWIDTH   = GATE_BITWIDTH_DEF,
    parameter int PPR_SHIFT       = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STALL_WINDOWS   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clk_en_i,
    input  logic                     TACH_pin_i,
    input  logic [GATE_BITWIDTH-1:0] GATE_periodCounterValue_i,
    output logic [ADC_BITWIDTH-1:0]  SPEED_value_o,
    output logic                     SPEED_valid_o,
    output logic                     STALL_o
);

    localparam int                      PCNT_W      = ADC_BITWIDTH + PPR_SHIFT + 1;
    localparam logic [PCNT_W-1:0]       SPEED_MAX   = PCNT_W'((1 << ADC_BITWIDTH) - 1);
    localparam logic [GATE_BITWIDTH-1:0] GATE_ONE   = GATE_BITWIDTH'(1);
    localparam logic [2:0]              STALL_LIMIT = 3'(STALL_WINDOWS);

    // Saturating increment of the pulse counter.
    function automatic logic [PCNT_W-1:0] pulse_inc(input logic [PCNT_W-1:0] cnt,
                                                    input logic              inc);
        return (inc && (cnt != '1)) ? cnt + PCNT_W'(1) : cnt;
    endfunction

    // Scale raw pulses to revolutions and clamp to the output range.
    function automatic logic [ADC_BITWIDTH-1:0] speed_sat(input logic [PCNT_W-1:0] snap);
        logic [PCNT_W-1:0] revs;
        revs = snap >> PPR_SHIFT;
        return (revs > SPEED_MAX) ? '1 : revs[ADC_BITWIDTH-1:0];
    endfunction

    gate_state_t              state;
    gate_state_t              state_nxt;
    logic                     level_unused;
    logic                     rise;
    logic                     period_zero;
    logic                     close_tick;
    logic [GATE_BITWIDTH-1:0] gate_cnt;
    logic [PCNT_W-1:0]        pulse_cnt;
    logic [PCNT_W-1:0]        snapshot;
    logic [ADC_BITWIDTH-1:0]  speed_new;
    logic [2:0]               zero_cnt;
    logic [2:0]               zero_nxt;

    // Only the rising edge of the debounced level feeds the measurement.
    tach_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clk_en_i(clk_en_i),
        .raw_i   (TACH_pin_i),
        .level_o (level_unused),
        .rise_o  (rise)
    );

    assign period_zero = (GATE_periodCounterValue_i == '0);
    // >= lets a shortened period close an over-long window on the next tick.
    assign close_tick  = (state == COUNT) && clk_en_i && !period_zero &&
                         (gate_cnt >= (GATE_periodCounterValue_i - GATE_ONE));
    assign speed_new   = speed_sat(snapshot);
    assign zero_nxt    = (zero_cnt == 3'd7) ? zero_cnt : zero_cnt + 3'd1;

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; a zero period forces IDLE from any state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!period_zero) state_nxt = COUNT;
            COUNT:   if (close_tick)   state_nxt = LATCH;
            LATCH:   state_nxt = COUNT;
            default: state_nxt = IDLE;
        endcase
        if (period_zero) begin
            state_nxt = IDLE;
        end
    end

    // Gate and pulse counters; LATCH keeps counting into the new window.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gate_cnt  <= '0;
            pulse_cnt <= '0;
            snapshot  <= '0;
        end else if (period_zero || (state == IDLE)) begin
            gate_cnt  <= '0;
            pulse_cnt <= '0;
        end else if (close_tick) begin
            gate_cnt  <= '0;
            pulse_cnt <= '0;
            snapshot  <= pulse_inc(pulse_cnt, rise);
        end else begin
            if (clk_en_i) begin
                gate_cnt <= gate_cnt + GATE_ONE;
            end
            pulse_cnt <= pulse_inc(pulse_cnt, rise);
        end
    end

    // Result stage: publish speed, strobe valid and track consecutive zero windows.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            SPEED_value_o <= '0;
            SPEED_valid_o <= 1'b0;
            STALL_o       <= 1'b0;
            zero_cnt      <= '0;
        end else begin
            SPEED_valid_o <= (state == LATCH);
            if (state == LATCH) begin
                SPEED_value_o <= speed_new;
                if (speed_new == '0) begin
                    zero_cnt <= zero_nxt;
                    if (zero_nxt >= STALL_LIMIT) begin
                        STALL_o <= 1'b1;
                    end
                end else begin
                    zero_cnt <= '0;
                    STALL_o  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fan_tach_meter.sv
// Directed bench for fan_tach_meter: steady speed, stall set/clear,
// saturation, reset mid-window, glitch rejection and clk_en gating/disable.
`timescale 1ns/1ps
module tb_fan_tach_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        tach;
    logic [19:0] period;
    logic [3:0]  speed;
    logic        valid;
    logic        stall;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int tach_mode = 0;   // 0 low, 1 5/5, 2 6/6, 3 2-high-in-10
    int en_mode   = 0;   // 0 every clk, 1 every 4th clk

    always #500 clk = ~clk;

    fan_tach_meter #(
        .ADC_BITWIDTH   (4),
        .GATE_BITWIDTH  (20),
        .PPR_SHIFT      (1),
        .DEBOUNCE_CYCLES(4),
        .STALL_WINDOWS  (2)
    ) dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .clk_en_i                 (clk_en),
        .TACH_pin_i               (tach),
        .GATE_periodCounterValue_i(period),
        .SPEED_value_o            (speed),
        .SPEED_valid_o            (valid),
        .STALL_o                  (stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for the next valid strobe, counting negedges; n is the count.
    task automatic wait_valid(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < limit);
        if (!valid) check("valid_timeout", 32'(valid), 32'd1);
    endtask

    // Tach waveform and clk_en pattern generator, driven just after each posedge.
    initial begin
        int ph;
        int prev;
        int ecnt;
        ph = 0; prev = 0; ecnt = 0;
        tach = 1'b0;
        clk_en = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (tach_mode != prev) begin
                ph = 0;
                prev = tach_mode;
            end
            case (tach_mode)
                1: begin tach = (ph < 5); ph = (ph + 1) % 10; end
                2: begin tach = (ph < 6); ph = (ph + 1) % 12; end
                3: begin tach = (ph < 2); ph = (ph + 1) % 10; end
                default: tach = 1'b0;
            endcase
            if (en_mode == 0) begin
                clk_en = 1'b1;
            end else begin
                clk_en = (ecnt == 0);
                ecnt = (ecnt + 1) % 4;
            end
        end
    end

    initial begin
        int n;
        int vcount;
        rst = 1'b1;
        period = 20'd100;
        tach_mode = 1;
        repeat (3) @(negedge clk);
        check("reset_speed", 32'(speed), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        rst = 1'b0;

        // Steady 5/5 tach, period 100
        wait_valid(200, n);
        check("first_latency", n, 32'd102);
        @(negedge clk);
        check("valid_strobe", 32'(valid), 32'd0);
        wait_valid(200, n);
        check("steady_gap", n + 1, 32'd100);
        check("steady_speed", 32'(speed), 32'd5);
        check("steady_stall", 32'(stall), 32'd0);
        wait_valid(200, n);
        check("steady_speed2", 32'(speed), 32'd5);

        // Tach held low: stall on the second zero window
        tach_mode = 0;
        wait_valid(200, n);
        check("low_w1_speed", 32'(speed), 32'd0);
        check("low_w1_stall", 32'(stall), 32'd0);
        wait_valid(200, n);
        check("low_w2_speed", 32'(speed), 32'd0);
        check("low_w2_stall", 32'(stall), 32'd1);

        // Resume toggling: first nonzero window clears stall
        tach_mode = 1;
        wait_valid(200, n);
        check("recover_speed", 32'(speed), 32'd5);
        check("recover_stall", 32'(stall), 32'd0);

        // Saturation: ~33 rises in 400 ticks clamps to 15
        period = 20'd400;
        tach_mode = 2;
        wait_valid(500, n);
        wait_valid(500, n);
        check("sat_gap", n, 32'd400);
        check("sat_speed", 32'(speed), 32'd15);
        check("sat_stall", 32'(stall), 32'd0);

        // Reset mid-window, then a full 100-tick window
        repeat (49) @(negedge clk);
        period = 20'd100;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_speed", 32'(speed), 32'd0);
        check("rst_mid_valid", 32'(valid), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        wait_valid(200, n);
        check("rst_mid_latency", n, 32'd102);
        check("rst_mid_speed_after", 32'(speed), 32'd4);

        // Short glitches are rejected: zero speed, stall on second window
        tach_mode = 3;
        wait_valid(200, n);
        check("glitch_w1_speed", 32'(speed), 32'd0);
        check("glitch_w1_stall", 32'(stall), 32'd0);
        @(negedge clk);
        check("glitch_strobe", 32'(valid), 32'd0);
        wait_valid(200, n);
        check("glitch_w2_speed", 32'(speed), 32'd0);
        check("glitch_w2_stall", 32'(stall), 32'd1);
        wait_valid(200, n);
        check("glitch_w3_stall", 32'(stall), 32'd1);

        // clk_en every 4th clk, period 25 -> 100 clks per window
        en_mode = 1;
        period = 20'd25;
        tach_mode = 0;
        wait_valid(600, n);
        @(negedge clk);
        wait_valid(300, n);
        check("en_gap", n + 1, 32'd100);
        wait_valid(300, n);
        check("en_gap2", n, 32'd100);

        // Disable mid-window: no strobes, outputs hold
        repeat (40) @(negedge clk);
        period = 20'd0;
        vcount = 0;
        repeat (300) begin
            @(negedge clk);
            if (valid) vcount++;
        end
        check("disabled_no_valid", vcount, 32'd0);
        check("disabled_speed_hold", 32'(speed), 32'd0);
        check("disabled_stall_hold", 32'(stall), 32'd1);

        // Re-enable: a full window before the next strobe
        period = 20'd25;
        wait_valid(200, n);
        check("reenable_latency", 32'(n >= 99 && n <= 102), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
